// File: rtl/conv_1_sdiv_seq.sv
// Sequential 24/8 signed divider: restoring radix-2, one quotient bit per cycle,
// valid/ready on both sides, saturating 16-bit quotient, 8-bit remainder.
module conv_1_sdiv_seq #(
  parameter int ID         = 32'd1,
  parameter int NUM_STAGE  = 32'd24,
  parameter int din0_WIDTH = 32'd24,
  parameter int din1_WIDTH = 32'd8,
  parameter int dout_WIDTH = 32'd16
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [dout_WIDTH-1:0] dout,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  ovf,
  output logic                  dbz
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [4:0] LP_LAST = 5'(NUM_STAGE - 32'd1);

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic        r_sign_n;
  logic        r_sign_d;
  logic        r_dbz_cap;
  logic [23:0] r_num;
  logic [23:0] r_quo;
  logic [7:0]  r_part;
  logic [7:0]  r_den;
  logic        r_in_ready;
  logic        r_out_valid;
  logic [15:0] r_dout;
  logic [7:0]  r_rem;
  logic        r_ovf;
  logic        r_dbz;

  logic [23:0] w_abs_n;
  logic [7:0]  w_abs_d;
  logic [8:0]  w_trial;
  logic        w_ge;
  logic [8:0]  w_part_nxt;
  logic [23:0] w_quo_nxt;
  logic        w_neg;
  logic [15:0] w_dout_fin;
  logic [7:0]  w_rem_fin;
  logic        w_ovf_fin;
  logic        w_unused;

  assign w_abs_n    = din0[23] ? (24'd0 - din0) : din0;
  assign w_abs_d    = din1[7] ? (8'd0 - din1) : din1;
  assign w_trial    = {r_part, r_num[23]};
  assign w_ge       = (w_trial >= {1'b0, r_den});
  assign w_part_nxt = w_ge ? (w_trial - {1'b0, r_den}) : w_trial;
  assign w_quo_nxt  = {r_quo[22:0], w_ge};
  assign w_neg      = r_sign_n ^ r_sign_d;
  // The remainder is always below |divisor| <= 128, so bit 8 never survives a step.
  assign w_unused   = &{1'b0, ID[0], w_part_nxt[8]};

  // Sign restoration, saturation and divide-by-zero override of the final step.
  always_comb begin
    w_dout_fin = 16'd0;
    w_rem_fin  = 8'd0;
    w_ovf_fin  = 1'b0;
    if (r_dbz_cap) begin
      w_dout_fin = r_sign_n ? 16'h8000 : 16'h7FFF;
    end else begin
      w_rem_fin = r_sign_n ? (8'd0 - w_part_nxt[7:0]) : w_part_nxt[7:0];
      if (!w_neg && (w_quo_nxt > 24'd32767)) begin
        w_dout_fin = 16'h7FFF;
        w_ovf_fin  = 1'b1;
      end else if (w_neg && (w_quo_nxt > 24'd32768)) begin
        w_dout_fin = 16'h8000;
        w_ovf_fin  = 1'b1;
      end else if (w_neg) begin
        w_dout_fin = 16'd0 - w_quo_nxt[15:0];
      end else begin
        w_dout_fin = w_quo_nxt[15:0];
      end
    end
  end

  // Control FSM, operand capture, restoring iteration and result registers.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 5'd0;
      r_sign_n    <= 1'b0;
      r_sign_d    <= 1'b0;
      r_dbz_cap   <= 1'b0;
      r_num       <= 24'd0;
      r_quo       <= 24'd0;
      r_part      <= 8'd0;
      r_den       <= 8'd0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_dout      <= 16'd0;
      r_rem       <= 8'd0;
      r_ovf       <= 1'b0;
      r_dbz       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sign_n   <= din0[23];
            r_sign_d   <= din1[7];
            r_dbz_cap  <= (din1 == 8'd0);
            r_num      <= w_abs_n;
            r_den      <= w_abs_d;
            r_part     <= 8'd0;
            r_quo      <= 24'd0;
            r_cnt      <= 5'd0;
            r_in_ready <= 1'b0;
            r_state    <= S_CALC;
          end
        end
        S_CALC: begin
          r_num  <= {r_num[22:0], 1'b0};
          r_part <= w_part_nxt[7:0];
          r_quo  <= w_quo_nxt;
          r_cnt  <= r_cnt + 5'd1;
          if (r_cnt == LP_LAST) begin
            r_dout      <= w_dout_fin;
            r_rem       <= w_rem_fin;
            r_ovf       <= w_ovf_fin;
            r_dbz       <= r_dbz_cap;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign dout      = r_dout;
  assign rem       = r_rem;
  assign ovf       = r_ovf;
  assign dbz       = r_dbz;

endmodule

// File: tb/tb_conv_1_sdiv_seq.sv
// Self-checking bench for conv_1_sdiv_seq: directed table, backpressure and reset
// sequences, then randomized operands against a plain-arithmetic reference.
module tb_conv_1_sdiv_seq;

  logic        ap_clk;
  logic        ap_rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] din0;
  logic [7:0]  din1;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] dout;
  logic [7:0]  rem;
  logic        ovf;
  logic        dbz;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int n;
    int d;
    int q;
    int r;
    int o;
    int z;
  } vec_t;

  vec_t tbl[11];

  conv_1_sdiv_seq dut (
    .ap_clk   (ap_clk),
    .ap_rst   (ap_rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .din0     (din0),
    .din1     (din1),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .dout     (dout),
    .rem      (rem),
    .ovf      (ovf),
    .dbz      (dbz)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // C-style truncating division with saturation, zero-divisor rule applied first.
  function automatic void model(input int n, input int d, output int q, output int r,
                                output int o, output int z);
    int qq;
    if (d == 0) begin
      q = (n < 0) ? -32768 : 32767;
      r = 0;
      o = 0;
      z = 1;
    end else begin
      qq = n / d;
      r  = n % d;
      z  = 0;
      if (qq > 32767) begin
        q = 32767;
        o = 1;
      end else if (qq < -32768) begin
        q = -32768;
        o = 1;
      end else begin
        q = qq;
        o = 0;
      end
    end
  endfunction

  function automatic vec_t mk(input int n, input int d, input int q, input int r,
                              input int o, input int z);
    vec_t v;
    v.n = n; v.d = d; v.q = q; v.r = r; v.o = o; v.z = z;
    return v;
  endfunction

  task automatic run_op(input int n, input int d, input int eq, input int er, input int eo,
                        input int ez, input bit do_hs, input string tag);
    int lat;
    bit got;
    @(negedge ap_clk);
    for (int i = 0; i < 40 && !in_ready; i++) @(negedge ap_clk);
    chk({tag, "_in_ready"}, int'(in_ready), 1);
    in_valid = 1'b1;
    din0     = n[23:0];
    din1     = d[7:0];
    @(posedge ap_clk);
    #1;
    in_valid = 1'b0;
    din0     = 24'($urandom);
    din1     = 8'($urandom);
    chk({tag, "_accepted"}, int'(in_ready), 0);
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge ap_clk);
      #1;
      lat++;
      if (out_valid) got = 1'b1;
    end
    chk({tag, "_latency"}, got ? lat : -1, 24);
    chk({tag, "_dout"}, int'($signed(dout)), eq);
    chk({tag, "_rem"}, int'($signed(rem)), er);
    chk({tag, "_ovf"}, int'(ovf), eo);
    chk({tag, "_dbz"}, int'(dbz), ez);
    if (do_hs) begin
      @(negedge ap_clk);
      out_ready = 1'b1;
      @(posedge ap_clk);
      #1;
      out_ready = 1'b0;
      chk({tag, "_hs_valid"}, int'(out_valid), 0);
      chk({tag, "_hs_ready"}, int'(in_ready), 1);
    end
  endtask

  initial begin
    int q, r, o, z, n, d;
    ap_rst    = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    din0      = 24'd0;
    din1      = 8'd0;

    tbl[0]  = mk(1000, 7, 142, 6, 0, 0);
    tbl[1]  = mk(-1000, 7, -142, -6, 0, 0);
    tbl[2]  = mk(1000, -7, -142, 6, 0, 0);
    tbl[3]  = mk(-1000, -7, 142, -6, 0, 0);
    tbl[4]  = mk(8388607, 1, 32767, 0, 1, 0);
    tbl[5]  = mk(-8388608, 1, -32768, 0, 1, 0);
    tbl[6]  = mk(-8388608, -128, 32767, 0, 1, 0);
    tbl[7]  = mk(32768, 1, 32767, 0, 1, 0);
    tbl[8]  = mk(500, 0, 32767, 0, 0, 1);
    tbl[9]  = mk(-500, 0, -32768, 0, 0, 1);
    tbl[10] = mk(-32768, 1, -32768, 0, 0, 0);

    #2;
    ap_rst = 1'b1;
    repeat (2) @(posedge ap_clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_dout", int'(dout), 0);
    chk("rst_rem", int'(rem), 0);
    chk("rst_flags", int'({ovf, dbz}), 0);
    @(negedge ap_clk);
    ap_rst = 1'b0;

    for (int i = 0; i < 11; i++)
      run_op(tbl[i].n, tbl[i].d, tbl[i].q, tbl[i].r, tbl[i].o, tbl[i].z, 1'b1,
             $sformatf("vec%0d", i));

    // Backpressure: result held, in_valid pulses ignored while in DONE.
    run_op(1000, 7, 142, 6, 0, 0, 1'b0, "bp");
    for (int i = 0; i < 10; i++) begin
      @(negedge ap_clk);
      in_valid = 1'b1;
      din0     = 24'd77;
      din1     = 8'd5;
      @(posedge ap_clk);
      #1;
      in_valid = 1'b0;
      chk("bp_hold_valid", int'(out_valid), 1);
      chk("bp_hold_ready", int'(in_ready), 0);
      chk("bp_hold_dout", int'($signed(dout)), 142);
      chk("bp_hold_rem", int'($signed(rem)), 6);
    end
    @(negedge ap_clk);
    out_ready = 1'b1;
    @(posedge ap_clk);
    #1;
    out_ready = 1'b0;
    chk("bp_release_valid", int'(out_valid), 0);
    chk("bp_release_ready", int'(in_ready), 1);
    run_op(-1000, -7, 142, -6, 0, 0, 1'b1, "bp_next");

    // Asynchronous reset in the middle of CALC.
    @(negedge ap_clk);
    in_valid = 1'b1;
    din0     = 24'd5000;
    din1     = 8'd3;
    @(posedge ap_clk);
    #1;
    in_valid = 1'b0;
    repeat (12) @(posedge ap_clk);
    #3;
    ap_rst = 1'b1;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_in_ready", int'(in_ready), 1);
    chk("arst_dout", int'(dout), 0);
    chk("arst_rem", int'(rem), 0);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    run_op(100, 3, 33, 1, 0, 0, 1'b1, "after_rst");

    // Randomized operands against the reference model.
    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(0, 2))
        0: n = int'($signed(24'($urandom)));
        1: n = int'($signed(17'($urandom)));
        default: n = int'($signed(12'($urandom)));
      endcase
      d = ($urandom_range(0, 15) == 0) ? 0 : int'($signed(8'($urandom)));
      model(n, d, q, r, o, z);
      run_op(n, d, q, r, o, z, 1'b1, $sformatf("rnd%0d_%0d_%0d", i, n, d));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/conv_1_sdiv_seq.md
# conv_1_sdiv_seq

Sequential signed divider, 24-bit dividend by 8-bit divisor, producing a 16-bit quotient and an 8-bit remainder. It is the inverse of the conv_1 16x8 signed multiplier: it rescales accumulated convolution products back to 16-bit sample range. It uses a multi-cycle valid/ready handshake and a radix-2 non-performing (restoring) iteration, one quotient bit per cycle, so no DSP is consumed.

## Interface
Parameters:
- ID, 32'd1, instance tag; no functional effect.
- NUM_STAGE, 32'd24, informational latency; must equal 24.
- din0_WIDTH, 32'd24, dividend width; only 24 supported.
- din1_WIDTH, 32'd8, divisor width; only 8 supported.
- dout_WIDTH, 32'd16, quotient width; only 16 supported.

Ports:
- ap_clk  in  1  clock, rising edge.
- ap_rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands.
- din0  in  24  signed dividend.
- din1  in  8  signed divisor.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- dout  out  16  signed quotient, saturated.
- rem  out  8  signed remainder.
- ovf  out  1  quotient saturated.
- dbz  out  1  divisor was zero.

## Operation
- States: IDLE, CALC, DONE. Reset puts the block in IDLE.
- IDLE: in_ready=1. When in_valid=1, the operands are captured, the state goes to CALC, and the iteration counter is set to 0.
- Capture: register sign_n=din0[23], sign_d=din1[7] and dbz=(din1==0). Register |din0| as a 24-bit unsigned value; -8388608 maps to 0x800000. Register |din1| as an 8-bit unsigned value; -128 maps to 0x80.
- CALC: one restoring step per cycle, MSB first.
  - partial remainder (9 bits) = {partial, next dividend bit}.
  - If partial >= |divisor|: subtract |divisor| and shift in quotient bit 1. Otherwise shift in 0.
  - The state goes to DONE after step 24 (counter 23).
- Finalization, on the edge that enters DONE:
  - q = sign_n^sign_d ? -Q : Q.
  - r = sign_n ? -R : R. Division truncates toward zero, as in C, and the remainder takes the sign of the dividend.
  - Saturation:
    - If q > 32767: dout=32767, ovf=1.
    - If q < -32768: dout=-32768, ovf=1.
    - Otherwise dout=q[15:0], ovf=0.
  - Divide by zero (dbz=1): dout = sign_n ? -32768 : 32767, rem=0, ovf=0, dbz=1. CALC still runs for the full 24 cycles, so latency stays constant.
- DONE: out_valid=1, and dout/rem/ovf/dbz are held stable. When out_ready=1, the state returns to IDLE. No new operand is accepted in the same cycle; in_ready=0 in DONE.
- in_valid is ignored outside IDLE.
- Reset at any time, including mid-CALC or in DONE with out_ready=0, aborts the operation. No stale result is presented afterwards.

## Timing
- Reset values:
  - state=IDLE
  - in_ready=1
  - out_valid=0
  - dout=0, rem=0
  - ovf=0, dbz=0
  - internal registers = 0
- Let edge T be the edge where in_valid & in_ready. CALC covers edges T+1 .. T+24. out_valid is 1 after edge T+24. Latency is 24 cycles, independent of the data.
- Result handshake completes at edge U, where out_valid & out_ready. After U: out_valid=0 and in_ready=1. The earliest next acceptance is edge U+1.
- Throughput: one result per 26 cycles with no backpressure.
- in_ready and out_valid are pure functions of state, with no combinational path from in_valid or out_ready.
- Outputs are registered. dout, rem, ovf and dbz change only on the edge entering DONE, or on reset.

## Test plan
- 1000 / 7 -> dout=142, rem=6, ovf=0, dbz=0. out_valid rises exactly 24 cycles after acceptance.
- Sign cases:
  - -1000 / 7 -> dout=-142, rem=-6.
  - 1000 / -7 -> dout=-142, rem=6.
  - -1000 / -7 -> dout=142, rem=-6.
- Saturation:
  - 8388607 / 1 -> dout=32767, ovf=1.
  - -8388608 / 1 -> dout=-32768, ovf=1.
  - -8388608 / -128 -> dout=32767, ovf=1.
  - 32768 / 1 -> dout=32767, ovf=1.
- Divide by zero:
  - 500 / 0 -> dout=32767, rem=0, dbz=1.
  - -500 / 0 -> dout=-32768, dbz=1. Latency is still 24 cycles.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after out_valid. Outputs stay stable and in_ready stays 0 while in_valid is pulsed.
  - Release out_ready. After one cycle, in_ready=1. A back-to-back operand is accepted on the next edge.
- Reset: assert ap_rst asynchronously (not aligned to a clock edge) at cycle 12 of CALC.
  - Immediately: out_valid=0, in_ready=1, dout=0.
  - Then issue 100 / 3 -> dout=33, rem=1, with no trace of the aborted operation.
